// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: boot loader FSM states and frame constants.
package arch_defs_pkg;

    // Boot loader sequencing states
    typedef enum logic [2:0] {
        S_RESET,
        S_INIT,
        S_LATCH_ADDR,
        S_READ_BYTE,
        S_LATCH_BYTE,
        S_CHK_MORE_BYTES,
        S_EXECUTE,
        S_HALT
    } fsm_state_t;

    // Header bytes preceding the payload: origin_hi, origin_lo, len_hi, len_lo
    localparam int unsigned BOOT_HDR_BYTES = 4;

endpackage

// File: rtl/boot_loader_ctrl.sv
// UART boot loader: receives a framed image, writes it to RAM, verifies the
// checksum, then releases the CPU and hands it the RAM write port.
module boot_loader_ctrl
    import arch_defs_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  boot_skip,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
    input  logic [DATA_WIDTH-1:0] cpu_mem_wdata,
    input  logic                  cpu_mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  boot_done,
    output logic                  boot_error
);

    localparam int LEN_WIDTH = 2 * DATA_WIDTH;

    fsm_state_t              state, next_state;

    logic [1:0]              hdr_idx;
    logic [DATA_WIDTH-1:0]   origin_hi, origin_lo, len_hi;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [LEN_WIDTH-1:0]    remaining;
    logic [DATA_WIDTH-1:0]   sum;
    logic [DATA_WIDTH-1:0]   data_latch;
    logic                    chk_phase;

    logic                    rx_fire;
    logic                    hdr_last;
    logic [LEN_WIDTH-1:0]    hdr_len;
    logic [ADDR_WIDTH-1:0]   origin;
    logic [DATA_WIDTH-1:0]   chk_total;

    assign rx_fire   = rx_valid && rx_ready;
    assign hdr_last  = (hdr_idx == 2'(BOOT_HDR_BYTES - 1));
    assign hdr_len   = {len_hi, rx_data};
    assign origin    = ADDR_WIDTH'({origin_hi, origin_lo});
    assign chk_total = sum + rx_data;

    // State register; reset wins over any transfer on the same edge
    always_ff @(posedge clk) begin
        if (reset) state <= S_RESET;
        else       state <= next_state;
    end

    // Next-state decode, handshake, status and the inline RAM port mux
    always_comb begin
        next_state = state;
        rx_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = origin + offset;
        mem_wdata  = data_latch;
        cpu_hold   = 1'b1;
        boot_done  = 1'b0;
        boot_error = 1'b0;
        case (state)
            S_RESET: next_state = S_INIT;
            S_INIT:  next_state = boot_skip ? S_EXECUTE : S_LATCH_ADDR;
            S_LATCH_ADDR: begin
                rx_ready = 1'b1;
                if (rx_fire && hdr_last)
                    next_state = (hdr_len == '0) ? S_HALT : S_READ_BYTE;
            end
            S_READ_BYTE: begin
                rx_ready = 1'b1;
                if (rx_fire) begin
                    if (!chk_phase)          next_state = S_LATCH_BYTE;
                    else if (chk_total == '0) next_state = S_EXECUTE;
                    else                     next_state = S_HALT;
                end
            end
            S_LATCH_BYTE: begin
                mem_we     = 1'b1;
                next_state = S_CHK_MORE_BYTES;
            end
            S_CHK_MORE_BYTES: next_state = S_READ_BYTE;
            S_EXECUTE: begin
                cpu_hold  = 1'b0;
                boot_done = 1'b1;
                mem_addr  = cpu_mem_addr;
                mem_wdata = cpu_mem_wdata;
                mem_we    = cpu_mem_we;
            end
            S_HALT:  boot_error = 1'b1;
            default: next_state = S_RESET;
        endcase
    end

    // Frame datapath: header capture, payload latch, running sum and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_idx    <= '0;
            origin_hi  <= '0;
            origin_lo  <= '0;
            len_hi     <= '0;
            offset     <= '0;
            remaining  <= '0;
            sum        <= '0;
            data_latch <= '0;
            chk_phase  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    hdr_idx   <= '0;
                    offset    <= '0;
                    remaining <= '0;
                    sum       <= '0;
                    chk_phase <= 1'b0;
                end
                S_LATCH_ADDR: begin
                    if (rx_fire) begin
                        case (hdr_idx)
                            2'd0:    origin_hi <= rx_data;
                            2'd1:    origin_lo <= rx_data;
                            2'd2:    len_hi    <= rx_data;
                            default: remaining <= hdr_len;
                        endcase
                        hdr_idx <= hdr_idx + 2'd1;
                    end
                end
                S_READ_BYTE: begin
                    if (rx_fire && !chk_phase) data_latch <= rx_data;
                end
                S_LATCH_BYTE: sum <= sum + data_latch;
                S_CHK_MORE_BYTES: begin
                    offset    <= offset + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == LEN_WIDTH'(1)) chk_phase <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Testbench for boot_loader_ctrl: table of frames plus hand-written sequences
// for mid-load reset and boot_skip hand-off; RAM writes checked via a queue.
module tb_boot_loader_ctrl;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          boot_skip = 1'b0;
    logic [AW-1:0] cpu_mem_addr = '0;
    logic [DW-1:0] cpu_mem_wdata = '0;
    logic          cpu_mem_we = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          cpu_hold;
    logic          boot_done;
    logic          boot_error;

    boot_loader_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .boot_skip    (boot_skip),
        .cpu_mem_addr (cpu_mem_addr),
        .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_we   (cpu_mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .cpu_hold     (cpu_hold),
        .boot_done    (boot_done),
        .boot_error   (boot_error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_e;

    typedef struct {
        logic [7:0]  b [8];
        int unsigned n;
        logic        gaps;
        logic        exp_done;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the oldest expected write
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL write_unexpected: got addr %0h data %0h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", 32'(mem_addr), 32'(mon_e[23:8]));
                chk("write_data", 32'(mem_wdata), 32'(mon_e[7:0]));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready",   32'(rx_ready),   32'(0));
        chk("rst_mem_we",     32'(mem_we),     32'(0));
        chk("rst_cpu_hold",   32'(cpu_hold),   32'(1));
        chk("rst_boot_done",  32'(boot_done),  32'(0));
        chk("rst_boot_error", 32'(boot_error), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic gaps);
        int unsigned t;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        rx_data  = d;
        rx_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rx_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (t >= 100) chk("rx_ready_timeout", 32'(rx_ready), 32'(1));
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Sends frame k with the CPU port trying to write; only loader writes may appear
    task automatic load_frame(input int unsigned k);
        logic [15:0] origin, len;
        int unsigned t;
        origin = {vecs[k].b[0], vecs[k].b[1]};
        len    = {vecs[k].b[2], vecs[k].b[3]};
        cpu_mem_addr  = 16'h1234;
        cpu_mem_wdata = 8'hEE;
        cpu_mem_we    = 1'b1;
        for (int unsigned i = 0; i < vecs[k].n; i++) begin
            if (i == vecs[k].n - 1) cpu_mem_we = 1'b0;
            if (i >= 4 && i < 4 + 32'(len))
                exp_q.push_back({origin + 16'(i - 4), vecs[k].b[i]});
            send_byte(vecs[k].b[i], vecs[k].gaps);
        end
        cpu_mem_we = 1'b0;
        t = 0;
        @(negedge clk);
        while (!(boot_done || boot_error) && t < 50) begin
            t++;
            @(negedge clk);
        end
        chk($sformatf("v%0d_boot_done", k),  32'(boot_done),  32'(vecs[k].exp_done));
        chk($sformatf("v%0d_boot_error", k), 32'(boot_error), 32'(!vecs[k].exp_done));
        chk($sformatf("v%0d_cpu_hold", k),   32'(cpu_hold),   32'(!vecs[k].exp_done));
        chk($sformatf("v%0d_writes_left", k), 32'(exp_q.size()), 32'(0));
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_hold_rx_ready", k), 32'(rx_ready), 32'(0));
        chk($sformatf("v%0d_hold_error", k),    32'(boot_error), 32'(!vecs[k].exp_done));
        chk($sformatf("v%0d_hold_cpu_hold", k), 32'(cpu_hold),   32'(!vecs[k].exp_done));
    endtask

    initial begin
        vecs[0].b = '{8'hF0, 8'h00, 8'h00, 8'h03, 8'hA9, 8'h05, 8'h01, 8'h51};
        vecs[0].n = 8; vecs[0].gaps = 1'b0; vecs[0].exp_done = 1'b1;
        vecs[1].b = '{8'hF0, 8'h00, 8'h00, 8'h03, 8'hA9, 8'h05, 8'h01, 8'h50};
        vecs[1].n = 8; vecs[1].gaps = 1'b0; vecs[1].exp_done = 1'b0;
        vecs[2].b = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'hCD, 8'h00};
        vecs[2].n = 7; vecs[2].gaps = 1'b0; vecs[2].exp_done = 1'b1;
        vecs[3].b = '{8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].n = 4; vecs[3].gaps = 1'b0; vecs[3].exp_done = 1'b0;
        vecs[4].b = vecs[0].b;
        vecs[4].n = 8; vecs[4].gaps = 1'b1; vecs[4].exp_done = 1'b1;

        for (int unsigned k = 0; k < 5; k++) begin
            do_reset();
            load_frame(k);
        end

        // Reset after first payload byte, coinciding with a live transfer
        do_reset();
        send_byte(8'hF0, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        exp_q.push_back({16'hF000, 8'hA9});
        send_byte(8'hA9, 1'b0);
        rx_data  = 8'h05;
        rx_valid = 1'b1;
        begin
            int unsigned t;
            t = 0;
            @(negedge clk);
            while (!rx_ready && t < 20) begin
                t++;
                @(negedge clk);
            end
            chk("midrst_rx_ready_before", 32'(rx_ready), 32'(1));
        end
        reset = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'(1));
        chk("midrst_rx_ready", 32'(rx_ready), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_writes_left", 32'(exp_q.size()), 32'(0));
        load_frame(4);

        // boot_skip: CPU released by cycle 3, then owns the RAM port
        boot_skip = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("skip_cpu_hold",  32'(cpu_hold),  32'(0));
        chk("skip_boot_done", 32'(boot_done), 32'(1));
        #1;
        exp_q.push_back({16'h0200, 8'h7E});
        cpu_mem_addr  = 16'h0200;
        cpu_mem_wdata = 8'h7E;
        cpu_mem_we    = 1'b1;
        @(negedge clk);
        chk("skip_mem_we",   32'(mem_we),   32'(1));
        chk("skip_mem_addr", 32'(mem_addr), 32'h0200);
        @(posedge clk); #1;
        cpu_mem_we = 1'b0;
        boot_skip  = 1'b0;
        @(negedge clk);
        chk("skip_writes_left", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
